// File: rtl/rvfi_commit_gen.sv
// Retire-side commit packet producer with order counter, halt stop, and sticky PC/watchdog error.
// Latency 1 cycle (registered packet); no backpressure, every RUN-state retire is emitted.
module rvfi_commit_gen #(
  parameter int unsigned WATCHDOG  = 1000,
  parameter logic [31:0] HALT_INST = 32'h0000006f,
  parameter logic [31:0] RESET_PC  = 32'h40000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [31:0] wb_inst,
  input  logic [4:0]  wb_rs1_addr,
  input  logic [4:0]  wb_rs2_addr,
  input  logic [31:0] wb_rs1_rdata,
  input  logic [31:0] wb_rs2_rdata,
  input  logic        wb_regf_we,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_wdata,
  input  logic [31:0] wb_pc_rdata,
  input  logic [31:0] wb_pc_wdata,
  input  logic [31:0] wb_mem_addr,
  input  logic [3:0]  wb_mem_rmask,
  input  logic [3:0]  wb_mem_wmask,
  input  logic [31:0] wb_mem_rdata,
  input  logic [31:0] wb_mem_wdata,
  output logic        mon_valid,
  output logic [63:0] mon_order,
  output logic [31:0] mon_inst,
  output logic [4:0]  mon_rs1_addr,
  output logic [4:0]  mon_rs2_addr,
  output logic [31:0] mon_rs1_rdata,
  output logic [31:0] mon_rs2_rdata,
  output logic [4:0]  mon_rd_addr,
  output logic [31:0] mon_rd_wdata,
  output logic [31:0] mon_pc_rdata,
  output logic [31:0] mon_pc_wdata,
  output logic [31:0] mon_mem_addr,
  output logic [3:0]  mon_mem_rmask,
  output logic [3:0]  mon_mem_wmask,
  output logic [31:0] mon_mem_rdata,
  output logic [31:0] mon_mem_wdata,
  output logic        mon_load_regfile,
  output logic        mon_halt,
  output logic        err,
  output logic [1:0]  err_cause
);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        running, commit, is_halt, load_rf;
  logic [63:0] order_cnt;
  logic [31:0] expected_pc;
  logic [31:0] wd_cnt, wd_nxt;
  logic        wd_trip;
  logic [1:0]  cause_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_RUN && wb_valid && wb_inst == HALT_INST) state_nxt = S_HALTED;
  end

  always_comb begin
    running = (state == S_RUN);
    commit  = running && wb_valid;
  end

  assign is_halt = (wb_inst == HALT_INST);
  assign load_rf = wb_regf_we && (wb_rd_addr != 5'd0);

  // Watchdog trips on the cycle the count would reach WATCHDOG, so err shows after exactly WATCHDOG idle edges.
  always_comb begin
    wd_nxt  = wd_cnt;
    wd_trip = 1'b0;
    if (WATCHDOG != 0 && running) begin
      if (wb_valid)                wd_nxt = 32'd0;
      else if (wd_cnt < WATCHDOG)  wd_nxt = wd_cnt + 32'd1;
      wd_trip = !wb_valid && (wd_nxt == WATCHDOG);
    end
  end

  always_comb begin
    cause_nxt = 2'b00;
    if (commit && wb_pc_rdata != expected_pc) cause_nxt = 2'b01;
    else if (commit && wb_pc_wdata[1:0] != 2'b00) cause_nxt = 2'b10;
    else if (wd_trip) cause_nxt = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_valid        <= 1'b0;
      mon_order        <= 64'd0;
      mon_inst         <= 32'd0;
      mon_rs1_addr     <= 5'd0;
      mon_rs2_addr     <= 5'd0;
      mon_rs1_rdata    <= 32'd0;
      mon_rs2_rdata    <= 32'd0;
      mon_rd_addr      <= 5'd0;
      mon_rd_wdata     <= 32'd0;
      mon_pc_rdata     <= 32'd0;
      mon_pc_wdata     <= 32'd0;
      mon_mem_addr     <= 32'd0;
      mon_mem_rmask    <= 4'd0;
      mon_mem_wmask    <= 4'd0;
      mon_mem_rdata    <= 32'd0;
      mon_mem_wdata    <= 32'd0;
      mon_load_regfile <= 1'b0;
      mon_halt         <= 1'b0;
      err              <= 1'b0;
      err_cause        <= 2'b00;
      order_cnt        <= 64'd0;
      expected_pc      <= RESET_PC;
      wd_cnt           <= 32'd0;
    end else begin
      mon_valid <= commit;
      wd_cnt    <= wd_nxt;
      if (commit) begin
        mon_order        <= order_cnt;
        order_cnt        <= order_cnt + 64'd1;
        expected_pc      <= wb_pc_wdata;
        mon_inst         <= wb_inst;
        mon_rs1_addr     <= wb_rs1_addr;
        mon_rs2_addr     <= wb_rs2_addr;
        mon_rs1_rdata    <= wb_rs1_rdata;
        mon_rs2_rdata    <= wb_rs2_rdata;
        mon_rd_addr      <= load_rf ? wb_rd_addr : 5'd0;
        mon_rd_wdata     <= load_rf ? wb_rd_wdata : 32'd0;
        mon_pc_rdata     <= wb_pc_rdata;
        mon_pc_wdata     <= wb_pc_wdata;
        mon_mem_addr     <= wb_mem_addr;
        mon_mem_rmask    <= wb_mem_rmask;
        mon_mem_wmask    <= wb_mem_wmask;
        mon_mem_rdata    <= wb_mem_rdata;
        mon_mem_wdata    <= wb_mem_wdata;
        mon_load_regfile <= load_rf;
        mon_halt         <= is_halt;
      end
      // First error wins; later causes never overwrite.
      if (!err && cause_nxt != 2'b00) begin
        err       <= 1'b1;
        err_cause <= cause_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_commit_gen.sv
// Directed bench for rvfi_commit_gen: one instance with an 8-cycle watchdog, one with it disabled.
module tb_rvfi_commit_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_inst = '0;
  logic [4:0]  wb_rs1_addr = '0, wb_rs2_addr = '0, wb_rd_addr = '0;
  logic [31:0] wb_rs1_rdata = '0, wb_rs2_rdata = '0, wb_rd_wdata = '0;
  logic        wb_regf_we = 1'b0;
  logic [31:0] wb_pc_rdata = '0, wb_pc_wdata = '0;
  logic [31:0] wb_mem_addr = '0, wb_mem_rdata = '0, wb_mem_wdata = '0;
  logic [3:0]  wb_mem_rmask = '0, wb_mem_wmask = '0;

  logic        mon_valid, mon_load_regfile, mon_halt, err;
  logic [63:0] mon_order;
  logic [31:0] mon_inst, mon_rs1_rdata, mon_rs2_rdata, mon_rd_wdata, mon_pc_rdata, mon_pc_wdata;
  logic [31:0] mon_mem_addr, mon_mem_rdata, mon_mem_wdata;
  logic [4:0]  mon_rs1_addr, mon_rs2_addr, mon_rd_addr;
  logic [3:0]  mon_mem_rmask, mon_mem_wmask;
  logic [1:0]  err_cause;

  logic        z_valid, z_load_regfile, z_halt, z_err;
  logic [63:0] z_order;
  logic [31:0] z_inst, z_rs1_rdata, z_rs2_rdata, z_rd_wdata, z_pc_rdata, z_pc_wdata;
  logic [31:0] z_mem_addr, z_mem_rdata, z_mem_wdata;
  logic [4:0]  z_rs1_addr, z_rs2_addr, z_rd_addr;
  logic [3:0]  z_mem_rmask, z_mem_wmask;
  logic [1:0]  z_err_cause;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] RST_PC = 32'h40000000;
  localparam logic [31:0] HALT   = 32'h0000006f;

  always #5 clk = ~clk;

  rvfi_commit_gen #(.WATCHDOG(8)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_inst(wb_inst),
    .wb_rs1_addr(wb_rs1_addr), .wb_rs2_addr(wb_rs2_addr),
    .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
    .wb_regf_we(wb_regf_we), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .wb_pc_rdata(wb_pc_rdata), .wb_pc_wdata(wb_pc_wdata),
    .wb_mem_addr(wb_mem_addr), .wb_mem_rmask(wb_mem_rmask), .wb_mem_wmask(wb_mem_wmask),
    .wb_mem_rdata(wb_mem_rdata), .wb_mem_wdata(wb_mem_wdata),
    .mon_valid(mon_valid), .mon_order(mon_order), .mon_inst(mon_inst),
    .mon_rs1_addr(mon_rs1_addr), .mon_rs2_addr(mon_rs2_addr),
    .mon_rs1_rdata(mon_rs1_rdata), .mon_rs2_rdata(mon_rs2_rdata),
    .mon_rd_addr(mon_rd_addr), .mon_rd_wdata(mon_rd_wdata),
    .mon_pc_rdata(mon_pc_rdata), .mon_pc_wdata(mon_pc_wdata),
    .mon_mem_addr(mon_mem_addr), .mon_mem_rmask(mon_mem_rmask), .mon_mem_wmask(mon_mem_wmask),
    .mon_mem_rdata(mon_mem_rdata), .mon_mem_wdata(mon_mem_wdata),
    .mon_load_regfile(mon_load_regfile), .mon_halt(mon_halt),
    .err(err), .err_cause(err_cause)
  );

  rvfi_commit_gen #(.WATCHDOG(0)) dut0 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_inst(wb_inst),
    .wb_rs1_addr(wb_rs1_addr), .wb_rs2_addr(wb_rs2_addr),
    .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
    .wb_regf_we(wb_regf_we), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .wb_pc_rdata(wb_pc_rdata), .wb_pc_wdata(wb_pc_wdata),
    .wb_mem_addr(wb_mem_addr), .wb_mem_rmask(wb_mem_rmask), .wb_mem_wmask(wb_mem_wmask),
    .wb_mem_rdata(wb_mem_rdata), .wb_mem_wdata(wb_mem_wdata),
    .mon_valid(z_valid), .mon_order(z_order), .mon_inst(z_inst),
    .mon_rs1_addr(z_rs1_addr), .mon_rs2_addr(z_rs2_addr),
    .mon_rs1_rdata(z_rs1_rdata), .mon_rs2_rdata(z_rs2_rdata),
    .mon_rd_addr(z_rd_addr), .mon_rd_wdata(z_rd_wdata),
    .mon_pc_rdata(z_pc_rdata), .mon_pc_wdata(z_pc_wdata),
    .mon_mem_addr(z_mem_addr), .mon_mem_rmask(z_mem_rmask), .mon_mem_wmask(z_mem_wmask),
    .mon_mem_rdata(z_mem_rdata), .mon_mem_wdata(z_mem_wdata),
    .mon_load_regfile(z_load_regfile), .mon_halt(z_halt),
    .err(z_err), .err_cause(z_err_cause)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wb_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one retire for a single cycle; outputs are sampled 1 ns after the capturing edge.
  task automatic commit(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pcw,
                        input logic we, input logic [4:0] rd, input logic [31:0] wd);
    wb_valid    = 1'b1;
    wb_inst     = inst;
    wb_pc_rdata = pc;
    wb_pc_wdata = pcw;
    wb_regf_we  = we;
    wb_rd_addr  = rd;
    wb_rd_wdata = wd;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", mon_valid, 0);
    check("rst_order", mon_order, 0);
    check("rst_pc", mon_pc_rdata, 0);
    check("rst_err", {err, err_cause}, 0);

    // Three sequential commits, first with memory fields
    wb_mem_addr = 32'h1000; wb_mem_rmask = 4'hf; wb_mem_rdata = 32'hdeadbeef;
    wb_rs1_addr = 5'd3; wb_rs1_rdata = 32'h1234;
    commit(32'h00100093, RST_PC, RST_PC + 4, 1'b1, 5'd1, 32'd1);
    check("c0_valid", mon_valid, 1);
    check("c0_order", mon_order, 0);
    check("c0_rd", {mon_load_regfile, mon_rd_addr}, {1'b1, 5'd1});
    check("c0_mem", {mon_mem_addr, mon_mem_rmask, mon_mem_rdata}, {32'h1000, 4'hf, 32'hdeadbeef});
    check("c0_rs1", {mon_rs1_addr, mon_rs1_rdata}, {5'd3, 32'h1234});
    commit(32'h00200113, RST_PC + 4, RST_PC + 8, 1'b1, 5'd2, 32'd2);
    check("c1_order", {mon_valid, mon_order}, {1'b1, 64'd1});
    commit(32'h00300193, RST_PC + 8, RST_PC + 12, 1'b1, 5'd3, 32'd3);
    check("c2_order", {mon_valid, mon_order}, {1'b1, 64'd2});
    check("c2_rdw", mon_rd_wdata, 3);
    step();
    check("idle_valid", mon_valid, 0);
    check("c2_err", {err, err_cause}, 0);

    // Write to x0 is not a regfile load
    commit(32'h00100013, RST_PC + 12, RST_PC + 16, 1'b1, 5'd0, 32'd5);
    check("x0_load", mon_load_regfile, 0);
    check("x0_rd", {mon_rd_addr, mon_rd_wdata}, 0);
    check("x0_order", {mon_valid, mon_order}, {1'b1, 64'd3});

    // Halt idiom: one packet, then nothing; watchdog frozen afterwards
    commit(HALT, RST_PC + 16, RST_PC + 16, 1'b0, 5'd0, 32'd0);
    check("halt_pkt", {mon_valid, mon_halt, mon_order}, {1'b1, 1'b1, 64'd4});
    commit(32'h00100093, RST_PC + 16, RST_PC + 20, 1'b1, 5'd1, 32'd1);
    check("post_halt1", mon_valid, 0);
    commit(32'h00100093, RST_PC + 20, RST_PC + 24, 1'b1, 5'd1, 32'd1);
    check("post_halt2", mon_valid, 0);
    repeat (12) step();
    check("halt_wd_frozen", {mon_valid, err, err_cause}, 0);

    // PC discontinuity, then later misaligned target keeps first cause
    do_reset();
    commit(32'h00000013, RST_PC, RST_PC + 4, 1'b0, 5'd0, 32'd0);
    check("disc_c0_err", err, 0);
    commit(32'h00000013, 32'h40000100, 32'h40000104, 1'b0, 5'd0, 32'd0);
    check("disc_err", {mon_valid, err, err_cause}, {1'b1, 1'b1, 2'b01});
    commit(32'h00000013, 32'h40000104, 32'h40000102, 1'b0, 5'd0, 32'd0);
    check("disc_sticky", {mon_valid, err, err_cause}, {1'b1, 1'b1, 2'b01});

    // Misaligned target alone
    do_reset();
    commit(32'h00000013, RST_PC, 32'h40000002, 1'b0, 5'd0, 32'd0);
    check("mis_err", {err, err_cause}, {1'b1, 2'b10});

    // Both on one commit: discontinuity wins
    do_reset();
    commit(32'h00000013, RST_PC + 8, 32'h40000001, 1'b0, 5'd0, 32'd0);
    check("both_err", {err, err_cause}, {1'b1, 2'b01});

    // Watchdog: 8 idle edges trip it, disabled instance stays clean
    do_reset();
    repeat (7) step();
    check("wd_7", {err, err_cause}, 0);
    step();
    check("wd_8", {err, err_cause}, {1'b1, 2'b11});
    repeat (20) step();
    check("wd0_clean", {z_err, z_err_cause}, 0);

    // Reset mid-stream drops the packet immediately and restarts order/PC
    do_reset();
    for (int i = 0; i < 6; i++)
      commit(32'h00000013, RST_PC + 32'(4 * i), RST_PC + 32'(4 * i + 4), 1'b0, 5'd0, 32'd0);
    check("pre_rst", {mon_valid, mon_order}, {1'b1, 64'd5});
    rst = 1'b1;
    #1;
    check("async_rst", {mon_valid, mon_order}, 0);
    step();
    rst = 1'b0;
    commit(32'h00000013, RST_PC, RST_PC + 4, 1'b0, 5'd0, 32'd0);
    check("after_rst", {mon_valid, mon_order, 62'd0, err, err_cause}, {1'b1, 64'd0, 62'd0, 1'b0, 2'b00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
